// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads imem combinationally and queues {pc, instr} for decode.
// Optional macro FETCH_MISALIGN_CHECK_EN enables the sticky misaligned-redirect fault mode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);

  typedef enum logic {RUN, FAULT} mode_t;

  mode_t         mode_reg, mode_next;
  logic [31:0]   pc_reg, pc_next;
  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];

  logic pop, push, full;

  assign full      = (count_reg == FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid & out_ready;
  assign push      = (mode_reg == RUN) & ~redirect_valid & (~full | pop);
  assign imem_addr = pc_reg;
  assign out_pc    = q_pc[head_reg];
  assign out_instr = q_instr[head_reg];

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = (mode_reg == FAULT);
`else
  logic misalign_unused;
  assign misalign_unused = |redirect_pc[1:0];
  assign fetch_fault = 1'b0;
`endif

  // Next PC and mode; a redirect always wins over sequential fetch.
  always_comb begin
    mode_next = mode_reg;
    pc_next   = pc_reg;
    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      pc_next   = redirect_pc;
      mode_next = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
`else
      pc_next   = {redirect_pc[31:2], 2'b00};
      mode_next = RUN;
`endif
    end else if (push) begin
      pc_next = pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg  <= RUN;
      pc_reg    <= RESET_PC;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      mode_reg <= mode_next;
      pc_reg   <= pc_next;
      if (redirect_valid) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push) tail_reg <= tail_reg + 1'b1;
        if (pop)  head_reg <= head_reg + 1'b1;
        if (push && !pop)      count_reg <= count_reg + 1'b1;
        else if (pop && !push) count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Payload storage needs no reset: entries are only observed when counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail_reg]    <= pc_reg;
      q_instr[tail_reg] <= imem_instr;
    end
  end

endmodule
